// File: rtl/alu_pkg.sv
// Shared ALU package: opcode encodings and the default operand width.
// Build option: define ALU_PREPROCESS_NEG_CIN_EN to add the carry-in output
// used to turn the negate opcode into a two's-complement negation.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS_A = 3'b000,
        OP_NEG_A  = 3'b001,
        OP_ADD    = 3'b010,
        OP_INC    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_NOT_A  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_preprocess_map.sv
// alu_preprocess_map: combinational opcode decode producing the operand pair
// (and optionally the carry-in) that lets a single adder/logic unit compute
// every ALU operation.
// Ports:
//   a, b    : raw operands (WIDTH bits)
//   op      : 3-bit opcode
//   amod_c  : conditioned operand A (combinational)
//   bmod_c  : conditioned operand B (combinational)
//   cin_c   : adder carry-in, only with ALU_PREPROCESS_NEG_CIN_EN defined
module alu_preprocess_map
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] amod_c,
`ifdef ALU_PREPROCESS_NEG_CIN_EN
    output logic             cin_c,
`endif
    output logic [WIDTH-1:0] bmod_c
);

    // Opcode to operand-pair mapping; every code is decoded explicitly.
    always_comb begin
        amod_c = a;
        bmod_c = b;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
        cin_c  = 1'b0;
`endif
        case (alu_op_e'(op))
            OP_PASS_A: begin
                amod_c = '0;
                bmod_c = a;
            end
            OP_NEG_A: begin
                // 0 + ~A (+1 via carry-in when enabled) gives -A downstream
                amod_c = '0;
                bmod_c = ~a;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
                cin_c  = 1'b1;
`endif
            end
            OP_ADD: begin
                amod_c = a;
                bmod_c = b;
            end
            OP_INC: begin
                amod_c = a;
                bmod_c = WIDTH'(1);
            end
            OP_AND: begin
                amod_c = a;
                bmod_c = b;
            end
            OP_OR: begin
                amod_c = a;
                bmod_c = b;
            end
            OP_XOR: begin
                amod_c = a;
                bmod_c = b;
            end
            OP_NOT_A: begin
                amod_c = a;
                bmod_c = ~a;
            end
        endcase
    end

endmodule

// File: rtl/alu_preprocess.sv
// alu_preprocess: one-stage registered operand pre-conditioning in front of
// the ALU adder/logic unit. Decode lives in alu_preprocess_map; this level
// holds only the output registers and the valid flag.
// Build option: ALU_PREPROCESS_NEG_CIN_EN adds the registered cin output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : A/B/Op valid this cycle
//   A, B, Op   : operands and opcode
//   out_valid  : AMod/BMod/op_out (and cin) hold a fresh result
//   AMod, BMod : conditioned operands
//   op_out     : opcode registered with the data
//   cin        : carry-in for the adder (feature builds only)
module alu_preprocess
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  Op,
    output logic             out_valid,
    output logic [WIDTH-1:0] AMod,
    output logic [WIDTH-1:0] BMod,
`ifdef ALU_PREPROCESS_NEG_CIN_EN
    output logic             cin,
`endif
    output logic [OP_W-1:0]  op_out
);

    logic [WIDTH-1:0] amod_c;
    logic [WIDTH-1:0] bmod_c;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
    logic             cin_c;
`endif

    alu_preprocess_map #(
        .WIDTH (WIDTH)
    ) u_map (
        .a      (A),
        .b      (B),
        .op     (Op),
        .amod_c (amod_c),
`ifdef ALU_PREPROCESS_NEG_CIN_EN
        .cin_c  (cin_c),
`endif
        .bmod_c (bmod_c)
    );

    // Valid flag follows in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Data registers load only on a valid capture and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AMod   <= '0;
            BMod   <= '0;
            op_out <= '0;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
            cin    <= 1'b0;
`endif
        end else if (in_valid) begin
            AMod   <= amod_c;
            BMod   <= bmod_c;
            op_out <= Op;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
            cin    <= cin_c;
`endif
        end
    end

endmodule

// File: tb/tb_alu_preprocess.sv
// Scoreboard bench for alu_preprocess: the driver pushes model expectations,
// a monitor checks every cycle (fresh result, or held values when idle).
module tb_alu_preprocess;
    import alu_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0]    amod;
        logic [W-1:0]    bmod;
        logic [OP_W-1:0] op;
        logic            cin;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [OP_W-1:0] op;
    logic            out_valid;
    logic [W-1:0]    amod;
    logic [W-1:0]    bmod;
    logic [OP_W-1:0] op_out;
    logic            cin_w;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t last;

    alu_preprocess #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .Op        (op),
        .out_valid (out_valid),
        .AMod      (amod),
        .BMod      (bmod),
`ifdef ALU_PREPROCESS_NEG_CIN_EN
        .cin       (cin_w),
`endif
        .op_out    (op_out)
    );

`ifndef ALU_PREPROCESS_NEG_CIN_EN
    assign cin_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the downstream unit needs for each operation.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic [OP_W-1:0] xop);
        exp_t e;
        e.op  = xop;
        e.cin = 1'b0;
        e.amod = xa;
        e.bmod = xb;
        if (xop == OP_PASS_A) begin
            e.amod = '0;           // 0 + A
            e.bmod = xa;
        end else if (xop == OP_NEG_A) begin
            e.amod = '0;           // 0 + ~A (+1)
            e.bmod = ~xa;
`ifdef ALU_PREPROCESS_NEG_CIN_EN
            e.cin  = 1'b1;
`endif
        end else if (xop == OP_INC) begin
            e.bmod = W'(1);        // A + 1
        end else if (xop == OP_NOT_A) begin
            e.bmod = ~xa;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                last = '0;
            end else begin
                chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
                if (exp_q.size() != 0) last = exp_q.pop_front();
                chk("amod", int'(amod), int'(last.amod));
                chk("bmod", int'(bmod), int'(last.bmod));
                chk("op_out", int'(op_out), int'(last.op));
                chk("cin", int'(cin_w), int'(last.cin));
            end
        end
    end

    // Drive one cycle of input 2 units after an edge; capture at the next edge.
    task automatic drive(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [OP_W-1:0] xop);
        @(posedge clk);
        #2;
        in_valid = v;
        a  = xa;
        b  = xb;
        op = xop;
        if (v) exp_q.push_back(model(xa, xb, xop));
    endtask

    initial begin
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        rst_n = 1'b0;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_amod", int'(amod), 0);
        chk("rst_bmod", int'(bmod), 0);
        chk("rst_op_out", int'(op_out), 0);
        chk("rst_cin", int'(cin_w), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed plan: A=1010, B=0111 across all opcodes, back to back.
        for (int i = 0; i < 8; i++) drive(1'b1, 4'b1010, 4'b0111, 3'(i));
        drive(1'b0, 4'b0000, 4'b0000, 3'b000);

        // Explicit anchors for the directed plan on two opcodes.
        drive(1'b1, 4'b1010, 4'b0111, 3'b011);
        @(posedge clk); #1;
        chk("plan_inc_amod", int'(amod), 4'b1010);
        chk("plan_inc_bmod", int'(bmod), 4'b0001);
        in_valid = 1'b0;
        drive(1'b1, 4'b1010, 4'b0111, 3'b001);
        @(posedge clk); #1;
        chk("plan_neg_bmod", int'(bmod), 4'b0101);
        in_valid = 1'b0;

        // Single-cycle pulse then idle: out_valid drops, data holds.
        drive(1'b1, 4'b1010, 4'b0111, 3'b111);
        repeat (4) drive(1'b0, 4'b1111, 4'b1111, 3'b010);

        // Reset between edges while a result is showing.
        drive(1'b1, 4'b1010, 4'b0111, 3'b001);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_amod", int'(amod), 0);
        chk("midrst_bmod", int'(bmod), 0);
        chk("midrst_op_out", int'(op_out), 0);
        chk("midrst_cin", int'(cin_w), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 4'b0101, 4'b0101, 3'b110);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            ta = W'($urandom);
            tb = W'($urandom);
            drive(1'($urandom_range(0, 3) != 0), ta, tb, OP_W'($urandom));
        end
        drive(1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_preprocess.md
# alu_preprocess

Operand pre-conditioning stage in front of the ALU datapath adder/logic unit. From operands A, B and a 3-bit opcode it produces the modified operand pair (AMod, BMod) so that a single downstream adder/logic unit can compute every operation. Outputs are registered, with one pipeline stage, a valid flag and an opcode passed through alongside the data.

## Interface
- One clock; reset is asynchronous and active-low. Clock port `clk`, reset port `rst_n`.
- Parameter `WIDTH`, default 4: operand width in bits.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `in_valid` input, 1 bit: A/B/Op are valid this cycle.
- `A` input, WIDTH bits: operand A.
- `B` input, WIDTH bits: operand B.
- `Op` input, 3 bits: operation code.
- `out_valid` output, 1 bit: AMod/BMod/op_out hold a fresh result.
- `AMod` output, WIDTH bits: conditioned operand A.
- `BMod` output, WIDTH bits: conditioned operand B.
- `op_out` output, 3 bits: Op registered together with the data.
- `cin` output, 1 bit: carry-in for the downstream adder. Present only with `ALU_PREPROCESS_NEG_CIN_EN` defined.

## Operation
Mapping of Op to outputs:
- 000 (pass A): AMod=0, BMod=A.
- 001 (negate A): AMod=0, BMod=~A (ones' complement). cin=1 when the feature is enabled.
- 010 (A+B): AMod=A, BMod=B.
- 011 (A+1): AMod=A, BMod=1, zero-extended to WIDTH.
- 100 (AND): AMod=A, BMod=B.
- 101 (OR): AMod=A, BMod=B.
- 110 (XOR): AMod=A, BMod=B.
- 111 (NOT A): AMod=A, BMod=~A.

Rules:
- All 8 codes are defined. There is no default/illegal path.
- cin is 0 for every Op other than 001.
- Pure bitwise mapping: no arithmetic inside the block, no overflow handling.

## Timing
- Reset (`rst_n`=0, asynchronous): AMod=0, BMod=0, op_out=0, out_valid=0, cin=0, all immediately regardless of `clk`.
- Reset release: the first capture happens on the first rising edge with `rst_n`=1.
- Latency is 1 cycle. If `in_valid`=1 at edge N, the mapped values appear after edge N and `out_valid`=1 for that cycle.
- If `in_valid`=0 at an edge: `out_valid` goes to 0. AMod/BMod/op_out/cin hold their previous values and do not clear.
- Back-to-back `in_valid` gives one result per cycle. There is no backpressure.
- Reset asserted mid-stream drops the in-flight result. `out_valid` is 0 until a new valid input is captured.

## Configuration
- Macro `ALU_PREPROCESS_NEG_CIN_EN`.
- Defined: `cin` port exists and is registered with the data (1 only for Op=001), so the downstream adder yields the two's-complement -A.
- Undefined: `cin` port and its register are absent. Op=001 yields the ones' complement via 0 + ~A.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants OP_PASS_A=000, OP_NEG_A=001, OP_ADD=010, OP_INC=011, OP_AND=100, OP_OR=101, OP_XOR=110, OP_NOT_A=111.
  - A default WIDTH constant.
- Sub-module `alu_preprocess_map`: purely combinational Op→(AMod, BMod, cin) decode.
- Top level holds only the registers and valid logic.

## Test plan
All cases use A=1010, B=0111, `in_valid`=1, checked one cycle later with `out_valid`=1.
- Op=000 → AMod=0000, BMod=1010. Op=001 → AMod=0000, BMod=0101, cin=1 (macro defined).
- Op=010, 100, 101, 110 → AMod=1010, BMod=0111, cin=0.
- Op=011 → AMod=1010, BMod=0001. Op=111 → AMod=1010, BMod=0101.
- Drive `in_valid`=1 then 0 → `out_valid` pulses for exactly 1 cycle, and AMod/BMod hold their last values.
- Assert `rst_n`=0 between edges while `out_valid`=1 → all outputs are 0 immediately. After release, no `out_valid` until the next valid input.
